// File: rtl/fmul32_pkg.sv
// rtl/fmul32_pkg.sv - shared widths, exception bit indices and requester id type for the fmul32 issue arbiter
package fmul32_pkg;

    localparam int DATA_W      = 32;
    localparam int EXC_W       = 4;
    localparam int LAT_DEFAULT = 4;

    localparam int EXC_INF = 0;
    localparam int EXC_NAN = 1;
    localparam int EXC_OVF = 2;
    localparam int EXC_UNF = 3;

    typedef logic req_id_t;

endpackage

// File: rtl/fmul32_rsp_fifo.sv
// rtl/fmul32_rsp_fifo.sv - first-word-fall-through response FIFO with wrap-bit pointers
module fmul32_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Output forced to zero while empty so stale storage never leaks after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Credit admission guarantees a result never lands in a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fmul32_issue_arb.sv
// rtl/fmul32_issue_arb.sv - round-robin issue of two requesters onto one fixed-latency FMUL32 core with credit-protected response FIFOs
module fmul32_issue_arb
    import fmul32_pkg::*;
#(
    parameter int LAT   = LAT_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              core_valid,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic [DATA_W-1:0] core_res,
    input  logic [EXC_W-1:0]  core_exc,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic [EXC_W-1:0]  rsp0_exc,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [EXC_W-1:0]  rsp1_exc,
    output logic              busy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic [OCC_W-1:0] occ0;
    logic [OCC_W-1:0] occ1;
    req_id_t          ptr;
    logic             elig0;
    logic             elig1;
    logic             gnt0;
    logic             gnt1;
    logic             pop0;
    logic             pop1;
    logic [LAT:1]     tag_v;
    logic [LAT:1]     tag_id;
    logic             empty0;
    logic             empty1;
    logic             full0;
    logic             full1;

    // Eligibility is gated by rst_n so every output is quiet during reset.
    always_comb begin
        elig0 = rst_n && req0_valid && (occ0 < OCC_MAX);
        elig1 = rst_n && req1_valid && (occ1 < OCC_MAX);
        gnt0  = elig0 && (!elig1 || (ptr == 1'b0));
        gnt1  = elig1 && (!elig0 || (ptr == 1'b1));
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign core_valid = gnt0 || gnt1;
    assign core_a     = gnt0 ? req0_a : (gnt1 ? req1_a : '0);
    assign core_b     = gnt0 ? req0_b : (gnt1 ? req1_b : '0);

    assign rsp0_valid = !empty0;
    assign rsp1_valid = !empty1;
    assign pop0       = rsp0_valid && rsp0_ready;
    assign pop1       = rsp1_valid && rsp1_ready;
    assign busy       = (|tag_v) || !empty0 || !empty1;

    // Stage k of the tag pipe holds the op issued k cycles ago; stage LAT meets core_res.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            tag_v  <= '0;
            tag_id <= '0;
            occ0   <= '0;
            occ1   <= '0;
        end else begin
            if (elig0 && elig1) begin
                ptr <= ~ptr;
            end
            tag_v[1]  <= core_valid;
            tag_id[1] <= gnt1;
            for (int k = 2; k <= LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            case ({gnt0, pop0})
                2'b10:   occ0 <= occ0 + 1'b1;
                2'b01:   occ0 <= occ0 - 1'b1;
                default: occ0 <= occ0;
            endcase
            case ({gnt1, pop1})
                2'b10:   occ1 <= occ1 + 1'b1;
                2'b01:   occ1 <= occ1 - 1'b1;
                default: occ1 <= occ1;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) (occ0 <= OCC_MAX) && (occ1 <= OCC_MAX));

    fmul32_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + EXC_W)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_v[LAT] && (tag_id[LAT] == 1'b0)),
        .push_data ({core_res, core_exc}),
        .pop       (pop0),
        .pop_data  ({rsp0_data, rsp0_exc}),
        .empty     (empty0),
        .full      (full0)
    );

    fmul32_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + EXC_W)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_v[LAT] && (tag_id[LAT] == 1'b1)),
        .push_data ({core_res, core_exc}),
        .pop       (pop1),
        .pop_data  ({rsp1_data, rsp1_exc}),
        .empty     (empty1),
        .full      (full1)
    );

endmodule

// File: tb/tb_fmul32_issue_arb.sv
// tb/tb_fmul32_issue_arb.sv - scoreboard bench for the fmul32 issue arbiter with a stub fixed-latency core
module tb_fmul32_issue_arb;
    import fmul32_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              core_valid;
    logic [DATA_W-1:0] core_a, core_b, core_res;
    logic [EXC_W-1:0]  core_exc;
    logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic [EXC_W-1:0]  rsp0_exc, rsp1_exc;
    logic              busy;

    always #5 clk = ~clk;

    fmul32_issue_arb #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .core_valid(core_valid), .core_a(core_a), .core_b(core_b),
        .core_res(core_res), .core_exc(core_exc),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_exc(rsp0_exc),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_exc(rsp1_exc),
        .busy(busy)
    );

    function automatic logic [31:0] core_fn(logic [31:0] a, logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return (a ^ (b << 1)) + 32'h0000_1234;
    endfunction

    function automatic logic [3:0] exc_fn(logic [31:0] a, logic [31:0] b);
        return a[3:0] ^ b[3:0];
    endfunction

    // Stub core: result of the operands presented at cycle T appears during cycle T+LAT.
    logic [31:0] pr [LAT];
    logic [3:0]  pe [LAT];
    always @(posedge clk) begin
        pr[0] <= core_fn(core_a, core_b);
        pe[0] <= exc_fn(core_a, core_b);
        for (int k = 1; k < LAT; k++) begin
            pr[k] <= pr[k-1];
            pe[k] <= pe[k-1];
        end
    end
    assign core_res = pr[LAT-1];
    assign core_exc = pe[LAT-1];

    typedef struct {
        logic [31:0] d;
        logic [3:0]  e;
        int          t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   ptr_m = 1'b0;
    bit   e0, e1, g0, g1, rv0, rv1;
    exp_t item;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: occupancy is the count of issued-but-unpopped ops per requester.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_core_valid", core_valid, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_busy", busy, 0);
            q0.delete();
            q1.delete();
            ptr_m = 1'b0;
        end else begin
            e0 = req0_valid && (q0.size() < DEPTH);
            e1 = req1_valid && (q1.size() < DEPTH);
            if (e0 && e1) begin
                g0 = !ptr_m;
                g1 = ptr_m;
            end else begin
                g0 = e0;
                g1 = e1;
            end
            chk("req0_ready", req0_ready, g0);
            chk("req1_ready", req1_ready, g1);
            chk("core_valid", core_valid, g0 || g1);
            chk("core_a", core_a, g0 ? req0_a : (g1 ? req1_a : 32'h0));
            chk("core_b", core_b, g0 ? req0_b : (g1 ? req1_b : 32'h0));
            rv0 = (q0.size() > 0) && (q0[0].t + LAT + 1 <= cyc);
            rv1 = (q1.size() > 0) && (q1[0].t + LAT + 1 <= cyc);
            chk("rsp0_valid", rsp0_valid, rv0);
            chk("rsp1_valid", rsp1_valid, rv1);
            chk("busy", busy, (q0.size() + q1.size()) > 0);
            if (rv0 && rsp0_ready) begin
                item = q0.pop_front();
                chk("rsp0_data", rsp0_data, item.d);
                chk("rsp0_exc", rsp0_exc, item.e);
            end
            if (rv1 && rsp1_ready) begin
                item = q1.pop_front();
                chk("rsp1_data", rsp1_data, item.d);
                chk("rsp1_exc", rsp1_exc, item.e);
            end
            if (g0) q0.push_back('{d: core_fn(req0_a, req0_b), e: exc_fn(req0_a, req0_b), t: cyc});
            if (g1) q1.push_back('{d: core_fn(req1_a, req1_b), e: exc_fn(req1_a, req1_b), t: cyc});
            if (e0 && e1) ptr_m = ~ptr_m;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        req0_a = $urandom;
        req0_b = $urandom;
        req1_a = $urandom;
        req1_b = $urandom;
    endtask

    task automatic rand_phase(int n, int rdy_pct);
        for (int i = 0; i < n; i++) begin
            rand_ops();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp0_ready = ($urandom_range(0, 99) < rdy_pct);
            rsp1_ready = ($urandom_range(0, 99) < rdy_pct);
            step();
        end
    endtask

    task automatic idle(int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        while (cyc < 10) step();

        // Single op on requester 0
        req0_valid = 1'b1;
        req0_a = 32'h4000_0000;
        req0_b = 32'h4040_0000;
        step();
        idle(8);

        // Contention for 8 cycles
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            step();
        end
        idle(8);

        // Backpressure on response 0, then a single-cycle pop
        rsp0_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            step();
        end
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        repeat (5) step();
        rsp0_ready = 1'b1;
        idle(12);

        // Exception flags on a requester 1 op
        req1_valid = 1'b1;
        req1_a = 32'h0000_0001;
        req1_b = 32'h0000_0000;
        step();
        idle(8);

        rand_phase(800, 25);
        rand_phase(800, 80);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        idle(12);

        // Reset with 2 buffered and 3 in flight
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        req0_valid = 1'b1;
        repeat (2) begin rand_ops(); step(); end
        idle(LAT);
        req1_valid = 1'b1;
        repeat (3) begin rand_ops(); step(); end
        rst_n = 1'b0;
        req0_valid = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            step();
        end
        rand_phase(300, 50);

        // Drain
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
